// File: rtl/fifo_word_serializer.sv
// Read-side FIFO drain that sends each DATA_SIZE-bit word MSB-first on tx_out with a tx_frame strobe.
// Optional: define FIFO_SERIALIZER_PARITY_EN to append an even-parity bit after the LSB.
module fifo_word_serializer #(
  parameter int DATA_SIZE  = 32,
  parameter int BIT_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 tx_out,
  output logic                 tx_frame,
  output logic                 busy,
  output logic [15:0]          word_count
);

  localparam int BCW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BCW-1:0] BIT_LOAD = BCW'(DATA_SIZE - 1);
  localparam logic [15:0]    DIV_LOAD = 16'(BIT_DIV - 1);
  localparam logic [15:0]    GAP_LOAD = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t               r_state;
  logic [DATA_SIZE-1:0] r_shift;
  logic [BCW-1:0]       r_bit_cnt;
  logic [15:0]          r_div_cnt;
  logic [15:0]          r_gap_cnt;
  logic [15:0]          r_word_count;
  logic                 r_tx_out;
  logic                 r_tx_frame;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic                 r_parity;
  logic                 r_par_phase;
`endif

  logic                 w_bit_done;
  logic                 w_last_bit;
  logic                 w_frame_done;
  logic [DATA_SIZE-1:0] w_shift_next;

  // NOTE: the read strobe is combinational so the FIFO pops in the same cycle the decision is made;
  // gating it with reset_n keeps a word from being popped while the block is held in reset.
  assign fifo_read    = reset_n && (r_state == IDLE) && enable && !fifo_empty;
  assign busy         = (r_state != IDLE);
  assign tx_out       = r_tx_out;
  assign tx_frame     = r_tx_frame;
  assign word_count   = r_word_count;

  assign w_bit_done   = (r_div_cnt == 16'd0);
  assign w_last_bit   = (r_bit_cnt == '0);
  assign w_shift_next = r_shift << 1;
`ifdef FIFO_SERIALIZER_PARITY_EN
  assign w_frame_done = w_bit_done && r_par_phase;
`else
  assign w_frame_done = w_bit_done && w_last_bit;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_word_count <= '0;
      r_tx_out     <= 1'b0;
      r_tx_frame   <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
      r_par_phase  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx_out   <= 1'b0;
          r_tx_frame <= 1'b0;
          if (fifo_read) r_state <= LOAD;
        end

        // fifo_data is valid now, one cycle after the strobe; first bit goes out next cycle.
        LOAD: begin
          r_shift    <= fifo_data;
          r_bit_cnt  <= BIT_LOAD;
          r_div_cnt  <= DIV_LOAD;
          r_tx_out   <= fifo_data[DATA_SIZE-1];
          r_tx_frame <= 1'b1;
`ifdef FIFO_SERIALIZER_PARITY_EN
          r_parity    <= ^fifo_data;
          r_par_phase <= 1'b0;
`endif
          r_state    <= SHIFT;
        end

        SHIFT: begin
          if (!w_bit_done) begin
            r_div_cnt <= r_div_cnt - 16'd1;
          end else if (w_frame_done) begin
            r_word_count <= r_word_count + 16'd1;
            r_tx_out     <= 1'b0;
            r_tx_frame   <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= GAP;
            end
`ifdef FIFO_SERIALIZER_PARITY_EN
          end else if (w_last_bit) begin
            r_par_phase <= 1'b1;
            r_div_cnt   <= DIV_LOAD;
            r_tx_out    <= r_parity;
`endif
          end else begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt - BCW'(1);
            r_div_cnt <= DIV_LOAD;
            r_tx_out  <= w_shift_next[DATA_SIZE-1];
          end
        end

        GAP: begin
          r_tx_out   <= 1'b0;
          r_tx_frame <= 1'b0;
          if (r_gap_cnt == 16'd0) r_state <= IDLE;
          else                    r_gap_cnt <= r_gap_cnt - 16'd1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
